// File: rtl/fifo_sram_pkg.sv
// Shared sizing helpers and parameter sanity checks for the packed-row SRAM FIFO.
package fifo_sram_pkg;

    // Total word capacity: every SRAM row holds PACK words.
    function automatic int calc_cap(input int depth, input int pack);
        return depth * pack;
    endfunction

    // Width of the occupancy counter, which must be able to hold CAP itself.
    function automatic int calc_lvl_w(input int depth, input int pack);
        return $clog2(depth * pack + 1);
    endfunction

    // SRAM row address width.
    function automatic int calc_aw(input int depth);
        return $clog2(depth);
    endfunction

    function automatic bit is_pow2(input int v);
        return (v > 0) && ((v & (v - 1)) == 0);
    endfunction

    // Legal parameter combinations for fifo_sram_pack.
    function automatic bit params_ok(input int width, input int depth,
                                     input int pack, input int sram_dw);
        return (width >= 1) && is_pow2(pack) && (pack >= 2) &&
               (pack * width <= sram_dw) && is_pow2(depth) && (depth >= 2);
    endfunction

endpackage

// File: rtl/fifo_row_buf.sv
// Read-side buffer: holds one unpacked row (or a flushed staging remainder)
// and presents its words one at a time on the read handshake.
module fifo_row_buf
    import fifo_sram_pkg::*;
#(
    parameter int WIDTH = 45,
    parameter int PACK  = 2
)(
    input  logic                          axis_clk,
    input  logic                          axi_reset_n,
    input  logic                          row_live,
    input  logic                          load_stage,
    input  logic [PACK*WIDTH-1:0]         row_data,
    input  logic [(PACK-1)*WIDTH-1:0]     stage_data,
    input  logic [$clog2(PACK)-1:0]       stage_cnt,
    input  logic                          pop,
    output logic                          r_vld,
    output logic [WIDTH-1:0]              data_out,
    output logic                          rbuf_free
);

    localparam int IW = $clog2(PACK);
    localparam int CW = $clog2(PACK + 1);

    logic [WIDTH-1:0] buf_q [PACK];
    logic [IW-1:0]    rd_idx_q;
    logic [CW-1:0]    cnt_q;
    logic [CW-1:0]    cnt_eff;

    // The cycle a fetched row returns from the SRAM it is served straight
    // from sram_dout as a full buffer at index 0, then latched; this keeps
    // the drain free of a bubble per row.
    assign cnt_eff   = row_live ? CW'(PACK) : cnt_q;
    assign r_vld     = (cnt_eff != '0);
    assign data_out  = row_live ? row_data[WIDTH-1:0] : buf_q[rd_idx_q];
    assign rbuf_free = (cnt_eff == '0) | ((cnt_eff == CW'(1)) & pop);

    // Buffer contents, read index and word count.
    always_ff @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                buf_q[i] <= '0;
            end
            rd_idx_q <= '0;
            cnt_q    <= '0;
        end else if (row_live) begin
            for (int unsigned i = 0; i < PACK; i++) begin
                buf_q[i] <= row_data[i*WIDTH +: WIDTH];
            end
            rd_idx_q <= pop ? IW'(1) : '0;
            cnt_q    <= pop ? CW'(PACK - 1) : CW'(PACK);
        end else if (load_stage) begin
            for (int unsigned i = 0; i < PACK - 1; i++) begin
                buf_q[i] <= stage_data[i*WIDTH +: WIDTH];
            end
            rd_idx_q <= '0;
            cnt_q    <= CW'(stage_cnt);
        end else if (pop) begin
            rd_idx_q <= rd_idx_q + IW'(1);
            cnt_q    <= cnt_q - CW'(1);
        end
    end

endmodule

// File: rtl/fifo_sram_pack.sv
// Stream FIFO packing PACK words per row of an external single-port SRAM,
// with a staging buffer on the write side and a row buffer on the read side.
module fifo_sram_pack
    import fifo_sram_pkg::*;
#(
    parameter  int WIDTH   = 45,
    parameter  int DEPTH   = 64,
    parameter  int PACK    = 2,
    parameter  int SRAM_DW = 128,
    localparam int CAP     = calc_cap(DEPTH, PACK),
    localparam int LVL_W   = calc_lvl_w(DEPTH, PACK),
    localparam int AW      = calc_aw(DEPTH)
)(
    input  logic               axis_clk,
    input  logic               axi_reset_n,
    input  logic               w_vld,
    output logic               w_rdy,
    input  logic [WIDTH-1:0]   data_in,
    output logic               r_vld,
    input  logic               r_rdy,
    output logic [WIDTH-1:0]   data_out,
    input  logic               th_en,
    input  logic [LVL_W-1:0]   th_reg,
    output logic [LVL_W-1:0]   level,
    output logic               above_th,
    output logic               sram_en,
    output logic               sram_we,
    output logic [AW-1:0]      sram_addr,
    output logic [SRAM_DW-1:0] sram_din,
    input  logic [SRAM_DW-1:0] sram_dout
);

    localparam int SW = $clog2(PACK);

    if (!params_ok(WIDTH, DEPTH, PACK, SRAM_DW)) begin : g_param_err
        $error("fifo_sram_pack: illegal WIDTH/DEPTH/PACK/SRAM_DW combination");
    end

    if (SRAM_DW > PACK * WIDTH) begin : g_pad
        logic unused_dout_bits;
        assign unused_dout_bits = ^sram_dout[SRAM_DW-1:PACK*WIDTH];
    end

    logic [LVL_W-1:0]          level_q;
    logic [WIDTH-1:0]          stage_q [PACK-1];
    logic [SW-1:0]             stage_cnt_q;
    logic [SW-1:0]             stage_wr_idx;
    logic [(PACK-1)*WIDTH-1:0] stage_flat;
    logic [AW-1:0]             wrow_q;
    logic [AW-1:0]             rrow_q;
    logic [AW:0]               sram_rows_q;
    logic                      fetch_inflight_q;
    logic [SRAM_DW-1:0]        row_wdata;

    logic accept;
    logic pop;
    logic commit;
    logic fetch;
    logic flush;
    logic rbuf_free;

    assign level    = level_q;
    assign above_th = (level_q > th_reg);
    assign w_rdy    = (level_q < LVL_W'(CAP)) & ~(th_en & above_th);

    assign accept = w_vld & w_rdy;
    assign pop    = r_vld & r_rdy;

    // A write that fills the last staging slot goes straight to the SRAM,
    // and owns the port that cycle; SRAM rows are always older than staging,
    // so staging may only bypass to the reader once the SRAM is drained.
    assign commit = accept & (stage_cnt_q == SW'(PACK - 1));
    assign fetch  = (sram_rows_q != '0) & rbuf_free & ~fetch_inflight_q & ~commit;
    assign flush  = (sram_rows_q == '0) & rbuf_free & ~fetch_inflight_q &
                    (stage_cnt_q != '0) & ~commit;

    assign stage_wr_idx = flush ? '0 : stage_cnt_q;

    assign sram_en   = commit | fetch;
    assign sram_we   = commit;
    assign sram_addr = commit ? wrow_q : rrow_q;
    assign sram_din  = commit ? row_wdata : '0;

    // Row image for a commit (slot 0 in the LSBs) and flat staging view.
    always_comb begin
        row_wdata  = '0;
        stage_flat = '0;
        for (int unsigned i = 0; i < PACK - 1; i++) begin
            row_wdata[i*WIDTH +: WIDTH]  = stage_q[i];
            stage_flat[i*WIDTH +: WIDTH] = stage_q[i];
        end
        row_wdata[(PACK-1)*WIDTH +: WIDTH] = data_in;
    end

    // Staging slots and fill count.
    always_ff @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            for (int unsigned i = 0; i < PACK - 1; i++) begin
                stage_q[i] <= '0;
            end
            stage_cnt_q <= '0;
        end else begin
            for (int unsigned i = 0; i < PACK - 1; i++) begin
                if (accept && !commit && (stage_wr_idx == SW'(i))) begin
                    stage_q[i] <= data_in;
                end
            end
            if (commit) begin
                stage_cnt_q <= '0;
            end else if (flush) begin
                stage_cnt_q <= accept ? SW'(1) : '0;
            end else if (accept) begin
                stage_cnt_q <= stage_cnt_q + SW'(1);
            end
        end
    end

    // SRAM row pointers, row count and read-in-flight flag.
    always_ff @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            wrow_q           <= '0;
            rrow_q           <= '0;
            sram_rows_q      <= '0;
            fetch_inflight_q <= 1'b0;
        end else begin
            if (commit) begin
                wrow_q      <= wrow_q + AW'(1);
                sram_rows_q <= sram_rows_q + (AW+1)'(1);
            end else if (fetch) begin
                rrow_q      <= rrow_q + AW'(1);
                sram_rows_q <= sram_rows_q - (AW+1)'(1);
            end
            fetch_inflight_q <= fetch;
        end
    end

    // Occupancy: words in staging, SRAM and the read buffer.
    always_ff @(posedge axis_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            level_q <= '0;
        end else if (accept && !pop) begin
            level_q <= level_q + LVL_W'(1);
        end else if (pop && !accept) begin
            level_q <= level_q - LVL_W'(1);
        end
    end

    fifo_row_buf #(
        .WIDTH (WIDTH),
        .PACK  (PACK)
    ) u_row_buf (
        .axis_clk    (axis_clk),
        .axi_reset_n (axi_reset_n),
        .row_live    (fetch_inflight_q),
        .load_stage  (flush),
        .row_data    (sram_dout[PACK*WIDTH-1:0]),
        .stage_data  (stage_flat),
        .stage_cnt   (stage_cnt_q),
        .pop         (pop),
        .r_vld       (r_vld),
        .data_out    (data_out),
        .rbuf_free   (rbuf_free)
    );

endmodule

// File: tb/tb_fifo_sram_pack.sv
// Scoreboard bench for fifo_sram_pack with a small SRAM model (WIDTH=8, DEPTH=4, PACK=2).
module tb_fifo_sram_pack;

    localparam int WIDTH   = 8;
    localparam int DEPTH   = 4;
    localparam int PACK    = 2;
    localparam int SRAM_DW = 32;
    localparam int LVL_W   = 4;
    localparam int AW      = 2;

    logic               axis_clk;
    logic               axi_reset_n;
    logic               w_vld;
    logic               w_rdy;
    logic [WIDTH-1:0]   data_in;
    logic               r_vld;
    logic               r_rdy;
    logic [WIDTH-1:0]   data_out;
    logic               th_en;
    logic [LVL_W-1:0]   th_reg;
    logic [LVL_W-1:0]   level;
    logic               above_th;
    logic               sram_en;
    logic               sram_we;
    logic [AW-1:0]      sram_addr;
    logic [SRAM_DW-1:0] sram_din;
    logic [SRAM_DW-1:0] sram_dout;

    int checks = 0;
    int errors = 0;
    int rd_count = 0;
    bit mon_en = 0;
    bit wr_done = 0;
    logic [WIDTH-1:0] exp_q [$];
    logic [SRAM_DW-1:0] mem [DEPTH];

    fifo_sram_pack #(
        .WIDTH   (WIDTH),
        .DEPTH   (DEPTH),
        .PACK    (PACK),
        .SRAM_DW (SRAM_DW)
    ) dut (
        .axis_clk    (axis_clk),
        .axi_reset_n (axi_reset_n),
        .w_vld       (w_vld),
        .w_rdy       (w_rdy),
        .data_in     (data_in),
        .r_vld       (r_vld),
        .r_rdy       (r_rdy),
        .data_out    (data_out),
        .th_en       (th_en),
        .th_reg      (th_reg),
        .level       (level),
        .above_th    (above_th),
        .sram_en     (sram_en),
        .sram_we     (sram_we),
        .sram_addr   (sram_addr),
        .sram_din    (sram_din),
        .sram_dout   (sram_dout)
    );

    initial axis_clk = 1'b0;
    always #5 axis_clk = ~axis_clk;

    // Single-port synchronous SRAM, read data one cycle after enable.
    initial sram_dout = '0;
    always @(posedge axis_clk) begin
        if (sram_en) begin
            if (sram_we) mem[sram_addr] <= sram_din;
            else         sram_dout <= mem[sram_addr];
        end
    end

    task automatic check(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Scoreboard monitor: push on accept, pop and compare on every read.
    always @(negedge axis_clk) begin
        if (mon_en && axi_reset_n) begin
            check("level_vs_model", level, exp_q.size());
            if (sram_we) check("sram_din_pad", sram_din[31:16], 0);
            if (w_vld && w_rdy) exp_q.push_back(data_in);
            if (r_vld && r_rdy) begin
                rd_count++;
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL rd_unexpected: got 0x%0h expected none", data_out);
                end else begin
                    check("rd_data", data_out, exp_q.pop_front());
                end
            end
        end
    end

    task automatic tick();
        @(posedge axis_clk);
        #1;
    endtask

    task automatic push_word(input logic [WIDTH-1:0] d, input int budget);
        bit ok;
        ok = 0;
        w_vld = 1'b1;
        data_in = d;
        for (int n = 0; n < budget && !ok; n++) begin
            @(negedge axis_clk);
            ok = w_rdy;
            tick();
        end
        w_vld = 1'b0;
        check("push_accepted", ok, 1);
    endtask

    task automatic wait_empty(input int budget);
        for (int n = 0; n < budget && level != 0; n++) tick();
        check("drain_done", level, 0);
    endtask

    initial begin
        int rd_before;
        axi_reset_n = 1'b0;
        w_vld = 1'b0;
        data_in = '0;
        r_rdy = 1'b0;
        th_en = 1'b0;
        th_reg = '0;

        // Reset values
        repeat (3) @(posedge axis_clk);
        @(negedge axis_clk);
        check("rst_w_rdy", w_rdy, 1);
        check("rst_r_vld", r_vld, 0);
        check("rst_data_out", data_out, 0);
        check("rst_level", level, 0);
        check("rst_above_th", above_th, 0);
        check("rst_sram_en", sram_en, 0);
        check("rst_sram_we", sram_we, 0);
        check("rst_sram_addr", sram_addr, 0);
        check("rst_sram_din", sram_din, 0);
        axi_reset_n = 1'b1;
        mon_en = 1;
        tick();

        // Single word through an empty FIFO: visible two cycles later
        r_rdy = 1'b1;
        w_vld = 1'b1;
        data_in = 8'h11;
        @(negedge axis_clk);
        check("single_w_rdy", w_rdy, 1);
        tick();
        w_vld = 1'b0;
        @(negedge axis_clk);
        check("single_t1_r_vld", r_vld, 0);
        check("single_t1_level", level, 1);
        @(negedge axis_clk);
        check("single_t2_r_vld", r_vld, 1);
        check("single_t2_data", data_out, 8'h11);
        check("single_t2_level", level, 1);
        @(negedge axis_clk);
        check("single_t3_level", level, 0);
        check("single_t3_r_vld", r_vld, 0);
        tick();

        // Fill to capacity, then drain bubble-free
        r_rdy = 1'b0;
        for (int k = 1; k <= 8; k++) push_word(8'(k), 4);
        w_vld = 1'b1;
        data_in = 8'h09;
        @(negedge axis_clk);
        check("full_w_rdy", w_rdy, 0);
        check("full_level", level, 8);
        check("full_r_vld", r_vld, 1);
        tick();
        w_vld = 1'b0;
        r_rdy = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge axis_clk);
            check("drain_continuous", r_vld, 1);
        end
        @(negedge axis_clk);
        check("drain_level", level, 0);
        check("drain_r_vld", r_vld, 0);
        tick();

        // Threshold backpressure at level 4, release with th_en=0
        r_rdy = 1'b0;
        th_en = 1'b1;
        th_reg = 4'd3;
        for (int k = 0; k < 4; k++) push_word(8'(8'h21 + k), 4);
        w_vld = 1'b1;
        data_in = 8'h25;
        for (int k = 0; k < 3; k++) begin
            @(negedge axis_clk);
            check("th_w_rdy", w_rdy, 0);
            check("th_above", above_th, 1);
            check("th_level", level, 4);
            tick();
        end
        th_en = 1'b0;
        for (int k = 0; k < 4; k++) push_word(8'(8'h25 + k), 4);
        @(negedge axis_clk);
        check("th_full_level", level, 8);
        check("th_full_w_rdy", w_rdy, 0);
        tick();

        // Accept and pop together at capacity: write waits one cycle
        w_vld = 1'b1;
        data_in = 8'h29;
        r_rdy = 1'b1;
        @(negedge axis_clk);
        check("fullsim_w_rdy", w_rdy, 0);
        check("fullsim_r_vld", r_vld, 1);
        tick();
        @(negedge axis_clk);
        check("fullsim_resume", w_rdy, 1);
        tick();
        w_vld = 1'b0;
        wait_empty(40);
        tick();

        // Streaming with random stalls on both sides
        rd_before = rd_count;
        wr_done = 0;
        fork
            begin
                for (int k = 0; k < 200; k++) begin
                    w_vld = 1'b0;
                    repeat ($urandom_range(0, 2)) tick();
                    push_word(8'(k), 50);
                end
                wr_done = 1;
            end
            begin
                for (int c = 0; c < 20000 && !(wr_done && exp_q.size() == 0); c++) begin
                    r_rdy = ($urandom_range(0, 3) != 0);
                    tick();
                end
            end
        join
        r_rdy = 1'b0;
        check("stream_drained", exp_q.size(), 0);
        check("stream_rd_count", rd_count - rd_before, 200);
        tick();

        // Reset with five words held; nothing stale may reappear
        for (int k = 0; k < 5; k++) push_word(8'(8'h51 + k), 4);
        @(negedge axis_clk);
        check("pre_rst_level", level, 5);
        tick();
        axi_reset_n = 1'b0;
        exp_q.delete();
        #1;
        check("mid_rst_level", level, 0);
        check("mid_rst_r_vld", r_vld, 0);
        check("mid_rst_w_rdy", w_rdy, 1);
        check("mid_rst_data_out", data_out, 0);
        check("mid_rst_sram_en", sram_en, 0);
        check("mid_rst_above_th", above_th, 0);
        @(negedge axis_clk);
        axi_reset_n = 1'b1;
        tick();
        r_rdy = 1'b1;
        push_word(8'hA5, 4);
        for (int n = 0; n < 10; n++) begin
            @(negedge axis_clk);
            if (r_vld) break;
        end
        check("post_rst_r_vld", r_vld, 1);
        check("post_rst_data", data_out, 8'hA5);
        repeat (3) tick();
        check("final_queue_empty", exp_q.size(), 0);
        check("final_level", level, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Absolute bound on run time.
    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

endmodule
